// File: rtl/mem_stage_pkg.sv
// Shared types and op codes for the MEM stage.
// Imported by mem_stage and mem_align.
package mem_stage_pkg;

  localparam int REG_W   = 32;
  localparam int RADDR_W = 5;
  localparam int ALUOP_W = 8;
  localparam int BE_W    = 4;

  localparam logic [ALUOP_W-1:0] EXOP_NOP = 8'h00;
  localparam logic [ALUOP_W-1:0] EXOP_ADD = 8'h01;
  localparam logic [ALUOP_W-1:0] EXOP_SUB = 8'h02;
  localparam logic [ALUOP_W-1:0] EXOP_LB  = 8'h20;
  localparam logic [ALUOP_W-1:0] EXOP_LH  = 8'h21;
  localparam logic [ALUOP_W-1:0] EXOP_LW  = 8'h22;
  localparam logic [ALUOP_W-1:0] EXOP_LBU = 8'h23;
  localparam logic [ALUOP_W-1:0] EXOP_LHU = 8'h24;
  localparam logic [ALUOP_W-1:0] EXOP_SB  = 8'h28;
  localparam logic [ALUOP_W-1:0] EXOP_SH  = 8'h29;
  localparam logic [ALUOP_W-1:0] EXOP_SW  = 8'h2a;

  typedef enum logic [1:0] {
    MEM_IDLE = 2'd0,
    MEM_BUSY = 2'd1,
    MEM_DONE = 2'd2
  } mem_state_t;

  function automatic logic [REG_W-1:0] word_addr(
    input logic [REG_W-1:0] a
  );
    return {a[REG_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/mem_align.sv
// Store lane steering, load extraction and misalignment check.
// Purely combinational; no state.
module mem_align
  import mem_stage_pkg::*;
(
  input  logic [ALUOP_W-1:0] aluop,
  input  logic [1:0]         off,
  input  logic [REG_W-1:0]   sdata,
  input  logic [REG_W-1:0]   rword,
  output logic               is_mem,
  output logic               is_load,
  output logic               is_store,
  output logic               mis,
  output logic [BE_W-1:0]    be,
  output logic [REG_W-1:0]   wdata,
  output logic [REG_W-1:0]   ldata
);

  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  always_comb begin
    rbyte = rword[7:0];
    unique case (off)
      2'd0: rbyte = rword[7:0];
      2'd1: rbyte = rword[15:8];
      2'd2: rbyte = rword[23:16];
      2'd3: rbyte = rword[31:24];
      default: rbyte = rword[7:0];
    endcase
  end

  assign rhalf = off[1] ? rword[31:16] : rword[15:0];

  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    mis      = 1'b0;
    be       = 4'b1111;
    wdata    = '0;
    ldata    = rword;
    unique case (aluop)
      EXOP_LB: begin
        is_load = 1'b1;
        ldata   = {{24{rbyte[7]}}, rbyte};
      end
      EXOP_LBU: begin
        is_load = 1'b1;
        ldata   = {24'd0, rbyte};
      end
      EXOP_LH: begin
        is_load = 1'b1;
        mis     = off[0];
        ldata   = {{16{rhalf[15]}}, rhalf};
      end
      EXOP_LHU: begin
        is_load = 1'b1;
        mis     = off[0];
        ldata   = {16'd0, rhalf};
      end
      EXOP_LW: begin
        is_load = 1'b1;
        mis     = |off;
      end
      EXOP_SB: begin
        is_store = 1'b1;
        be       = 4'b0001 << off;
        wdata    = {4{sdata[7:0]}};
      end
      EXOP_SH: begin
        is_store = 1'b1;
        mis      = off[0];
        be       = off[1] ? 4'b1100 : 4'b0011;
        wdata    = {2{sdata[15:0]}};
      end
      EXOP_SW: begin
        is_store = 1'b1;
        mis      = |off;
        wdata    = sdata;
      end
      default: ;
    endcase
  end

  assign is_mem = is_load | is_store;

endmodule

// File: rtl/mem_stage.sv
// MEM stage: req/ack data bus access with stall and timeout.
// wb_* doubles as the MEM-stage forwarding source for ID.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               me_w_enable,
  input  logic [RADDR_W-1:0] me_w_addr,
  input  logic [REG_W-1:0]   me_w_data,
  input  logic [ALUOP_W-1:0] me_aluop,
  input  logic [REG_W-1:0]   me_mem_addr,
  input  logic [5:0]         stall,
  output logic               wb_w_enable,
  output logic [RADDR_W-1:0] wb_w_addr,
  output logic [REG_W-1:0]   wb_w_data,
  output logic               stall_req,
  output logic               mem_req,
  output logic               mem_we,
  output logic [REG_W-1:0]   mem_addr,
  output logic [BE_W-1:0]    mem_be,
  output logic [REG_W-1:0]   mem_wdata,
  input  logic               mem_ack,
  input  logic [REG_W-1:0]   mem_rdata,
  output logic               misalign,
  output logic               bus_err
);

  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(TIMEOUT_CYCLES - 1);

  mem_state_t       state;
  mem_state_t       nstate;
  logic [CNT_W-1:0] cnt;
  logic [REG_W-1:0] rdata_q;

  logic             is_mem;
  logic             is_load;
  logic             is_store;
  logic             mis;
  logic [BE_W-1:0]  be_c;
  logic [REG_W-1:0] wdata_c;
  logic [REG_W-1:0] ldata;
  logic             timeout;

  logic unused_stall;
  assign unused_stall = ^{stall[5], stall[3:0]};

  mem_align u_align (
    .aluop    (me_aluop),
    .off      (me_mem_addr[1:0]),
    .sdata    (me_w_data),
    .rword    (rdata_q),
    .is_mem   (is_mem),
    .is_load  (is_load),
    .is_store (is_store),
    .mis      (mis),
    .be       (be_c),
    .wdata    (wdata_c),
    .ldata    (ldata)
  );

  assign timeout = (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst) state <= MEM_IDLE;
    else     state <= nstate;
  end

  always_comb begin
    nstate      = state;
    stall_req   = 1'b0;
    misalign    = 1'b0;
    wb_w_enable = me_w_enable;
    wb_w_addr   = me_w_addr;
    wb_w_data   = me_w_data;
    unique case (state)
      MEM_IDLE: begin
        if (is_mem && mis) begin
          misalign    = 1'b1;
          wb_w_enable = 1'b0;
        end else if (is_mem) begin
          stall_req   = 1'b1;
          wb_w_enable = 1'b0;
          nstate      = MEM_BUSY;
        end
      end
      MEM_BUSY: begin
        stall_req   = 1'b1;
        wb_w_enable = 1'b0;
        if (mem_ack || timeout) nstate = MEM_DONE;
      end
      MEM_DONE: begin
        if (is_load) wb_w_data   = ldata;
        else         wb_w_enable = 1'b0;
        if (!stall[4]) nstate = MEM_IDLE;
      end
      default: nstate = MEM_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= '0;
      mem_wdata <= '0;
      rdata_q   <= '0;
      bus_err   <= 1'b0;
    end else begin
      bus_err <= 1'b0;
      unique case (state)
        MEM_IDLE: begin
          if (nstate == MEM_BUSY) begin
            mem_req   <= 1'b1;
            mem_we    <= is_store;
            mem_addr  <= word_addr(me_mem_addr);
            mem_be    <= be_c;
            mem_wdata <= wdata_c;
            cnt       <= '0;
          end
        end
        MEM_BUSY: begin
          cnt <= cnt + 1'b1;
          // ack beats timeout when both land in the same cycle
          if (mem_ack) begin
            mem_req <= 1'b0;
            rdata_q <= mem_rdata;
          end else if (timeout) begin
            mem_req <= 1'b0;
            bus_err <= 1'b1;
            rdata_q <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage with a behavioural model.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        me_w_enable;
  logic [4:0]  me_w_addr;
  logic [31:0] me_w_data;
  logic [7:0]  me_aluop;
  logic [31:0] me_mem_addr;
  logic [5:0]  stall;
  logic        wb_w_enable;
  logic [4:0]  wb_w_addr;
  logic [31:0] wb_w_data;
  logic        stall_req;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        misalign;
  logic        bus_err;

  int tests = 0;
  int fails = 0;

  mem_stage #(.TIMEOUT_CYCLES(16), .CNT_W(5)) dut (
    .clk(clk), .rst(rst),
    .me_w_enable(me_w_enable), .me_w_addr(me_w_addr),
    .me_w_data(me_w_data), .me_aluop(me_aluop),
    .me_mem_addr(me_mem_addr), .stall(stall),
    .wb_w_enable(wb_w_enable), .wb_w_addr(wb_w_addr),
    .wb_w_data(wb_w_data), .stall_req(stall_req),
    .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .misalign(misalign),
    .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] op, input logic [31:0] a,
                       input logic [31:0] d, input logic en,
                       input logic [4:0] wa);
    me_aluop = op; me_mem_addr = a; me_w_data = d;
    me_w_enable = en; me_w_addr = wa;
  endtask

  task automatic nop();
    drive(EXOP_NOP, 32'h0, 32'h0, 1'b0, 5'd0);
  endtask

  function automatic int size_of(input logic [7:0] op);
    if (op == EXOP_LB || op == EXOP_LBU || op == EXOP_SB) return 1;
    if (op == EXOP_LH || op == EXOP_LHU || op == EXOP_SH) return 2;
    return 4;
  endfunction

  function automatic bit is_ld(input logic [7:0] op);
    return op == EXOP_LB || op == EXOP_LH || op == EXOP_LW ||
           op == EXOP_LBU || op == EXOP_LHU;
  endfunction

  function automatic logic [31:0] ref_load(input logic [7:0] op,
      input logic [31:0] a, input logic [31:0] w);
    logic [31:0] v;
    v = w >> ((a % 4) * 8);
    if (op == EXOP_LB || op == EXOP_LBU) v = v & 32'hFF;
    if (op == EXOP_LH || op == EXOP_LHU) v = v & 32'hFFFF;
    if (op == EXOP_LB && v >= 128) v = v | 32'hFFFF_FF00;
    if (op == EXOP_LH && v >= 32768) v = v | 32'hFFFF_0000;
    if (op == EXOP_LW) v = w;
    return v;
  endfunction

  function automatic logic [3:0] ref_be(input logic [7:0] op,
                                        input logic [31:0] a);
    if (op == EXOP_SB) return 4'(1 << (a % 4));
    if (op == EXOP_SH) return 4'(3 << (a % 4));
    return 4'hF;
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [7:0] op,
                                            input logic [31:0] d);
    if (op == EXOP_SB) return (d & 32'hFF) * 32'h0101_0101;
    if (op == EXOP_SH) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  // lat = 0 means the bus never acknowledges
  task automatic do_mem(input logic [7:0] op, input logic [31:0] a,
      input logic [31:0] d, input logic [31:0] rd, input int lat,
      input logic [4:0] wa, input string tag);
    int cyc;
    int nstall;
    int expect_busy;
    bit ld;
    ld = is_ld(op);
    expect_busy = (lat > 0) ? lat : 16;
    drive(op, a, d, 1'b1, wa);
    #1;
    chk({tag, " idle stall_req"}, 32'(stall_req), 1);
    chk({tag, " idle wb_en"}, 32'(wb_w_enable), 0);
    nstall = 1;
    tick();
    chk({tag, " req"}, 32'(mem_req), 1);
    chk({tag, " addr"}, mem_addr, a & 32'hFFFF_FFFC);
    chk({tag, " be"}, 32'(mem_be), 32'(ref_be(op, a)));
    chk({tag, " we"}, 32'(mem_we), ld ? 0 : 1);
    if (!ld) chk({tag, " wdata"}, mem_wdata, ref_wdata(op, d));
    for (cyc = 1; cyc <= 40; cyc++) begin
      if (stall_req) nstall++;
      if (cyc == lat) begin
        mem_ack = 1'b1;
        mem_rdata = rd;
      end
      tick();
      mem_ack = 1'b0;
      mem_rdata = $urandom;
      if (!mem_req) break;
    end
    chk({tag, " busy cycles"}, 32'(cyc), 32'(expect_busy));
    chk({tag, " stall cycles"}, 32'(nstall), 32'(expect_busy + 1));
    chk({tag, " done stall_req"}, 32'(stall_req), 0);
    chk({tag, " done bus_err"}, 32'(bus_err), (lat == 0) ? 1 : 0);
    chk({tag, " done wb_en"}, 32'(wb_w_enable), ld ? 1 : 0);
    if (ld) begin
      chk({tag, " done wb_data"}, wb_w_data,
          (lat > 0) ? ref_load(op, a, rd) : 32'h0);
      chk({tag, " done wb_addr"}, 32'(wb_w_addr), 32'(wa));
    end
    nop();
    tick();
    chk({tag, " after bus_err"}, 32'(bus_err), 0);
    chk({tag, " after req"}, 32'(mem_req), 0);
  endtask

  task automatic do_mis(input logic [7:0] op, input logic [31:0] a,
                        input string tag);
    drive(op, a, 32'h1111_2222, 1'b1, 5'd3);
    #1;
    chk({tag, " misalign"}, 32'(misalign), 1);
    chk({tag, " stall_req"}, 32'(stall_req), 0);
    chk({tag, " wb_en"}, 32'(wb_w_enable), 0);
    tick();
    chk({tag, " no req"}, 32'(mem_req), 0);
    nop();
    #1;
    chk({tag, " pulse end"}, 32'(misalign), 0);
  endtask

  logic [7:0] ops [8];
  int         reqs;

  initial begin
    ops[0] = EXOP_LB;  ops[1] = EXOP_LH;  ops[2] = EXOP_LW;
    ops[3] = EXOP_LBU; ops[4] = EXOP_LHU; ops[5] = EXOP_SB;
    ops[6] = EXOP_SH;  ops[7] = EXOP_SW;
    rst = 1'b1; stall = 6'd0; mem_ack = 1'b0; mem_rdata = 32'h0;
    nop();
    tick(); tick();
    chk("rst req", 32'(mem_req), 0);
    chk("rst be", 32'(mem_be), 0);
    chk("rst wb_en", 32'(wb_w_enable), 0);
    chk("rst wb_data", wb_w_data, 0);
    chk("rst bus_err", 32'(bus_err), 0);
    chk("rst misalign", 32'(misalign), 0);
    rst = 1'b0;
    tick();

    drive(EXOP_ADD, 32'h0, 32'h1234, 1'b1, 5'd5);
    #1;
    chk("add wb_data", wb_w_data, 32'h1234);
    chk("add wb_addr", 32'(wb_w_addr), 5);
    chk("add wb_en", 32'(wb_w_enable), 1);
    chk("add stall_req", 32'(stall_req), 0);
    tick();
    chk("add no req", 32'(mem_req), 0);
    nop();

    do_mem(EXOP_LB, 32'h103, 32'h0, 32'h80FF_FF00, 2, 5'd6, "lb");
    do_mem(EXOP_SH, 32'h202, 32'hABCD, 32'h0, 1, 5'd0, "sh");
    do_mis(EXOP_LW, 32'h101, "lw_mis");
    do_mis(EXOP_SH, 32'h203, "sh_mis");
    do_mem(EXOP_LW, 32'h500, 32'h0, 32'hDEAD_BEEF, 0, 5'd9, "lw_tmo");
    do_mem(EXOP_LW, 32'h504, 32'h0, 32'hCAFE_F00D, 16, 5'd9, "lw_edge");

    drive(EXOP_LB, 32'h400, 32'h0, 1'b1, 5'd4);
    tick();
    chk("rstbusy req", 32'(mem_req), 1);
    rst = 1'b1;
    nop();
    tick();
    rst = 1'b0;
    chk("rstbusy req drop", 32'(mem_req), 0);
    chk("rstbusy addr", mem_addr, 0);
    mem_ack = 1'b1;
    mem_rdata = 32'hFFFF_FFFF;
    drive(EXOP_ADD, 32'h0, 32'h55, 1'b1, 5'd7);
    #1;
    chk("rstbusy idle", 32'(stall_req), 0);
    chk("rstbusy pass", wb_w_data, 32'h55);
    tick();
    mem_ack = 1'b0;
    chk("late ack req", 32'(mem_req), 0);
    chk("late ack wb", wb_w_data, 32'h55);
    chk("late ack err", 32'(bus_err), 0);
    nop();

    reqs = 0;
    drive(EXOP_LHU, 32'h302, 32'h0, 1'b1, 5'd12);
    tick();
    if (mem_req) reqs++;
    mem_ack = 1'b1;
    mem_rdata = 32'h9876_5432;
    tick();
    mem_ack = 1'b0;
    stall = 6'b010000;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) stall = 6'd0;
      #1;
      if (mem_req) reqs++;
      chk("hold wb_data", wb_w_data, 32'h0000_9876);
      chk("hold wb_en", 32'(wb_w_enable), 1);
      chk("hold stall_req", 32'(stall_req), 0);
      if (i == 3) nop();
      tick();
    end
    if (mem_req) reqs++;
    chk("hold one access", 32'(reqs), 1);

    for (int n = 0; n < 24; n++) begin
      logic [7:0]  op;
      logic [31:0] a;
      int          sz;
      op = ops[$urandom_range(0, 7)];
      sz = size_of(op);
      a  = $urandom & 32'h0000_FFFC;
      if (sz == 1) a = a + 32'($urandom_range(0, 3));
      if (sz == 2) a = a + 32'(2 * $urandom_range(0, 1));
      if (sz > 1 && $urandom_range(0, 5) == 0) begin
        a = a + 32'(1 + (sz == 2 ? 2 * $urandom_range(0, 1)
                                  : $urandom_range(0, 2)));
        do_mis(op, a, "rnd_mis");
      end else begin
        do_mem(op, a, $urandom, $urandom, $urandom_range(1, 4),
               5'($urandom_range(1, 31)), "rnd");
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
